gauss_filter_param: RTL and testbench

GAUSS_FILTER_PARAM -- requirements
Module: gauss_filter_param

---
 rtl/gauss_pkg.sv | 38 +++
 rtl/gauss_linebuf.sv | 34 +++
 rtl/gauss_filter_param.sv | 189 ++++++++++++++++++
 tb/tb_gauss_filter_param.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// Shared constants and helpers for the parametrised Gaussian filter.
package gauss_pkg;

  // Unique-coefficient register indices (symmetric kernel).
  localparam logic [2:0] COE_C00 = 3'd0;
  localparam logic [2:0] COE_C01 = 3'd1;
  localparam logic [2:0] COE_C02 = 3'd2;
  localparam logic [2:0] COE_C11 = 3'd3;
  localparam logic [2:0] COE_C12 = 3'd4;
  localparam logic [2:0] COE_C22 = 3'd5;
  localparam int         COE_NUM = 6;

  // Enabled cycles from acceptance of a window-completing pixel to m_valid.
  localparam int LATENCY = 5;

  // Full-precision accumulator width: up to 25 products need 5 guard bits.
  function automatic int sum_width(input int data_w, input int coe_w);
    return data_w + coe_w + 5;
  endfunction

  // Only 3x3 and 5x5 kernels are supported.
  function automatic bit ksize_legal(input int k);
    return (k == 3) || (k == 5);
  endfunction

  // Fold a tap position onto its unique coefficient index.
  function automatic int coe_index(input int r, input int c, input int k);
    int a, b, lo, hi;
    a  = (r < k - 1 - r) ? r : k - 1 - r;
    b  = (c < k - 1 - c) ? c : k - 1 - c;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    if (lo == 0)      return hi;
    else if (lo == 1) return hi + 2;
    else              return 5;
  endfunction

endpackage

// File: rtl/gauss_linebuf.sv
// Cascaded line delay: ROWS lines of DEPTH pixels sharing one address.
// dout[r] is the pixel r+1 lines above the one currently on din.
module gauss_linebuf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int ROWS   = 4,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        en,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           din,
  output logic [ROWS-1:0][DATA_W-1:0] dout
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wdata;

    if (r == 0) begin : g_first
      assign wdata = din;
    end else begin : g_next
      assign wdata = dout[r-1];
    end

    // Each line shifts the pixel of the line below into its slot.
    always_ff @(posedge clk) begin
      if (en) mem[addr] <= wdata;
    end

    assign dout[r] = mem[addr];
  end

endmodule

// File: rtl/gauss_filter_param.sv
// KSIZE x KSIZE symmetric Gaussian filter over a raster pixel stream.
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high; valid never waits on ready, and once m_valid is high m_data and
// m_last hold until m_ready accepts the beat.
module gauss_filter_param
  import gauss_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 1024,
  parameter int KSIZE  = 5,
  parameter int COE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              coe_wen,
  input  logic [2:0]        coe_idx,
  input  logic [COE_W-1:0]  coe_data,
  input  logic              bypass,
  output logic              err_line
);

  if (!ksize_legal(KSIZE)) begin : g_bad_ksize
    $fatal(1, "gauss_filter_param: KSIZE must be 3 or 5");
  end

  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = $clog2(KSIZE);
  localparam int PROD_W = DATA_W + COE_W;
  localparam int SUM_W  = sum_width(DATA_W, COE_W);
  localparam int CTR    = (KSIZE - 1) / 2;
  localparam logic [SUM_W-1:0] PIX_MAX = SUM_W'((1 << DATA_W) - 1);
  localparam logic [SUM_W-1:0] HALF    = SUM_W'(1) << (COE_W - 1);

  logic en, acc;
  logic [COL_W-1:0] col_q, cur_col;
  logic [ROW_W-1:0] row_q, cur_row;
  logic col_end, wrap, win_ok;

  logic [COE_W-1:0] coe_shadow [COE_NUM];
  logic [COE_W-1:0] coe_act    [COE_NUM];

  logic [KSIZE-2:0][DATA_W-1:0] lb_dout;
  logic [DATA_W-1:0] newcol [KSIZE];
  logic [DATA_W-1:0] win    [KSIZE][KSIZE];

  logic [PROD_W-1:0] prod    [KSIZE][KSIZE];
  logic [SUM_W-1:0]  row_acc [KSIZE];
  logic [SUM_W-1:0]  rsum    [KSIZE];
  logic [SUM_W-1:0]  tot_acc, total, rnd, shifted;
  logic [DATA_W-1:0] result, ctr1, ctr2, ctr3;

  logic [LATENCY-1:0] vld_sr, last_sr;
  logic [LATENCY-2:0] byp_sr;

  // The whole pipeline advances unless a presented output is being held.
  assign en      = ~(m_valid & ~m_ready);
  assign s_ready = en;
  assign acc     = s_valid & s_ready;

  // A start-of-frame pixel is always column 0 of row 0.
  assign cur_col = s_sof ? '0 : col_q;
  assign cur_row = s_sof ? '0 : row_q;
  assign col_end = (cur_col == COL_W'(IMG_W - 1));
  assign wrap    = s_last | col_end;
  assign win_ok  = (cur_col >= COL_W'(KSIZE - 1)) && (cur_row >= ROW_W'(KSIZE - 1));

  // Position counters and line-length error; the row count saturates once
  // enough lines exist to form full windows.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      err_line <= 1'b0;
    end else if (acc) begin
      col_q <= wrap ? '0 : cur_col + COL_W'(1);
      if (wrap && cur_row != ROW_W'(KSIZE - 1)) row_q <= cur_row + ROW_W'(1);
      else                                      row_q <= cur_row;
      if (s_last != col_end) err_line <= 1'b1;
    end
  end

  // Coefficient writes land in the shadow set; a frame start commits them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COE_NUM; i++) begin
        coe_shadow[i] <= '0;
        coe_act[i]    <= '0;
      end
    end else begin
      if (coe_wen && coe_idx <= COE_C22) coe_shadow[coe_idx] <= coe_data;
      if (acc && s_sof) begin
        for (int i = 0; i < COE_NUM; i++) coe_act[i] <= coe_shadow[i];
      end
    end
  end

  gauss_linebuf #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .ROWS   (KSIZE - 1),
    .ADDR_W (COL_W)
  ) u_linebuf (
    .clk  (clk),
    .en   (acc),
    .addr (cur_col),
    .din  (s_data),
    .dout (lb_dout)
  );

  // New window column: oldest line at row 0, incoming pixel at the bottom.
  always_comb begin
    for (int i = 0; i < KSIZE - 1; i++) newcol[i] = lb_dout[KSIZE-2-i];
    newcol[KSIZE-1] = s_data;
  end

  // Window shifts left by one column per accepted pixel.
  always_ff @(posedge clk) begin
    if (acc) begin
      for (int i = 0; i < KSIZE; i++) begin
        for (int j = 0; j < KSIZE - 1; j++) win[i][j] <= win[i][j+1];
        win[i][KSIZE-1] <= newcol[i];
      end
    end
  end

  // Row partial sums and total of the registered products.
  always_comb begin
    for (int i = 0; i < KSIZE; i++) begin
      row_acc[i] = '0;
      for (int j = 0; j < KSIZE; j++) row_acc[i] = row_acc[i] + SUM_W'(prod[i][j]);
    end
  end

  always_comb begin
    tot_acc = '0;
    for (int i = 0; i < KSIZE; i++) tot_acc = tot_acc + rsum[i];
  end

  // Round to nearest, drop the fraction, clamp to the pixel range.
  always_comb begin
    rnd     = total + HALF;
    shifted = rnd >> COE_W;
    result  = (shifted > PIX_MAX) ? '1 : shifted[DATA_W-1:0];
  end

  // Datapath: products, row sums, total; centre pixel rides alongside.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < KSIZE; i++) begin
        for (int j = 0; j < KSIZE; j++) begin
          prod[i][j] <= PROD_W'(win[i][j]) * PROD_W'(coe_act[coe_index(i, j, KSIZE)]);
        end
        rsum[i] <= row_acc[i];
      end
      total <= tot_acc;
      ctr1  <= win[CTR][CTR];
      ctr2  <= ctr1;
      ctr3  <= ctr2;
    end
  end

  // Valid, line-end and bypass tags plus the registered output pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr  <= '0;
      last_sr <= '0;
      byp_sr  <= '0;
      m_data  <= '0;
    end else if (en) begin
      vld_sr  <= {vld_sr[LATENCY-2:0], acc & win_ok};
      last_sr <= {last_sr[LATENCY-2:0], acc & win_ok & col_end};
      byp_sr  <= {byp_sr[LATENCY-3:0], bypass};
      if (vld_sr[LATENCY-2]) m_data <= byp_sr[LATENCY-2] ? ctr3 : result;
    end
  end

  assign m_valid = vld_sr[LATENCY-1];
  assign m_last  = last_sr[LATENCY-1];

endmodule

// File: tb/tb_gauss_filter_param.sv
// Directed-plus-random bench for gauss_filter_param (KSIZE=3, IMG_W=8).
module tb_gauss_filter_param;

  localparam int DW   = 8;
  localparam int IW   = 8;
  localparam int K    = 3;
  localparam int CW   = 8;
  localparam int MAXH = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0, s_ready, s_sof = 1'b0, s_last = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic          coe_wen = 1'b0, bypass = 1'b0, err_line;
  logic [2:0]    coe_idx = '0;
  logic [CW-1:0] coe_data = '0;

  gauss_filter_param #(.DATA_W(DW), .IMG_W(IW), .KSIZE(K), .COE_W(CW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .coe_wen(coe_wen), .coe_idx(coe_idx), .coe_data(coe_data),
    .bypass(bypass), .err_line(err_line)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [DW:0] exp_q [$];
  int  img [MAXH][IW];
  int  coe_ref [3];   // c00, c01, c11
  int  new_set [3];
  bit  stall_mode = 0, gap_en = 1, lat_arm = 0;
  int  t_acc = -1, t_first = -1;
  bit  prev_stall = 0;
  logic [DW-1:0] held_d;
  logic          held_l;
  logic [DW:0]   mon_e;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_frame(input int h, input bit byp);
    int kern [K][K];
    int acc, v;
    logic [31:0] vv;
    kern = '{'{coe_ref[0], coe_ref[1], coe_ref[0]},
             '{coe_ref[1], coe_ref[2], coe_ref[1]},
             '{coe_ref[0], coe_ref[1], coe_ref[0]}};
    for (int r = K - 1; r < h; r++) begin
      for (int c = K - 1; c < IW; c++) begin
        acc = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            acc += img[r-K+1+i][c-K+1+j] * kern[i][j];
        v = (acc + (1 << (CW - 1))) >> CW;
        if (v > 255) v = 255;
        if (byp) v = img[r-1][c-1];
        vv = v;
        exp_q.push_back({(c == IW - 1), vv[DW-1:0]});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_pix(input logic [DW-1:0] d, input bit sof, input bit last);
    int n;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1; s_data = d; s_sof = sof; s_last = last;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 100);
    if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_sof = 1'b0; s_last = 1'b0;
  endtask

  task automatic write_coe(input logic [2:0] idx, input logic [CW-1:0] v);
    coe_idx = idx; coe_data = v; coe_wen = 1'b1;
    @(posedge clk);
    #1;
    coe_wen = 1'b0;
  endtask

  task automatic write_set(input int a, input int b, input int c);
    write_coe(3'd0, CW'(a));
    write_coe(3'd1, CW'(b));
    write_coe(3'd3, CW'(c));
  endtask

  task automatic send_frame(input int h, input int rw_row);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < IW; c++) begin
        send_pix(DW'(img[r][c]), (r == 0 && c == 0), (c == IW - 1));
        if (lat_arm && r == K - 1 && c == K - 1) t_acc = cyc;
        if (r == rw_row && c == 3) write_set(new_set[0], new_set[1], new_set[2]);
      end
    end
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < MAXH; r++) for (int c = 0; c < IW; c++) img[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < MAXH; r++) for (int c = 0; c < IW; c++) img[r][c] = $urandom_range(0, 255);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(held_d));
        check("stall_last", 32'(m_last), 32'(held_l));
      end
      if (lat_arm && t_first < 0 && m_valid === 1'b1) t_first = cyc;
      if (m_valid === 1'b1 && m_ready) begin
        check("out_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("out_pixel", 32'({m_last, m_data}), 32'(mon_e));
        end
      end
      prev_stall = (m_valid === 1'b1) && !m_ready;
      held_d = m_data;
      held_l = m_last;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_err_line", 32'(err_line), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);

    // Out-of-range indices must not disturb the set.
    write_coe(3'd6, 8'd255);
    write_coe(3'd7, 8'd255);
    write_set(16, 32, 64);
    coe_ref = '{16, 32, 64};

    // Constant frame, also measuring first-output latency.
    fill_const(100);
    model_frame(4, 0);
    gap_en = 0; lat_arm = 1; t_first = -1;
    send_frame(4, -1);
    drain();
    lat_arm = 0; gap_en = 1;
    // Accept edge plus four more edges: five enabled cycles.
    check("latency", 32'(t_first - t_acc), 32'd4);

    // Impulse response.
    fill_const(0);
    img[2][3] = 200;
    model_frame(4, 0);
    send_frame(4, -1);
    drain();

    // Random frame under random back-pressure.
    fill_rand();
    model_frame(5, 0);
    stall_mode = 1;
    send_frame(5, -1);
    drain();
    stall_mode = 0;

    // Bypass returns window centres.
    fill_rand();
    bypass = 1'b1;
    model_frame(4, 1);
    send_frame(4, -1);
    drain();
    bypass = 1'b0;

    // Rewrite mid-frame: current frame keeps old set, next frame uses new.
    fill_rand();
    new_set = '{8, 40, 96};
    model_frame(4, 0);
    send_frame(4, 2);
    coe_ref = new_set;
    fill_rand();
    model_frame(4, 0);
    send_frame(4, -1);
    drain();
    check("err_line_clean", 32'(err_line), 32'd0);

    // Saturation.
    for (int i = 0; i < 6; i++) write_coe(3'(i), 8'd255);
    coe_ref = '{255, 255, 255};
    fill_const(255);
    model_frame(3, 0);
    send_frame(3, -1);
    drain();

    // Short line sets the sticky error.
    for (int c = 0; c < 6; c++) send_pix(8'd7, (c == 0), (c == 5));
    check("err_short_line", 32'(err_line), 32'd1);
    model_frame(3, 0);
    send_frame(3, -1);
    drain();
    check("err_sticky", 32'(err_line), 32'd1);

    // Reset mid-frame with windows in flight.
    write_set(16, 32, 64);
    coe_ref = '{16, 32, 64};
    fill_const(100);
    gap_en = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < ((r == 2) ? 5 : IW); c++)
        send_pix(8'd100, (r == 0 && c == 0), (c == IW - 1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    gap_en = 1;
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_m_data", 32'(m_data), 32'd0);
    check("midrst_err_line", 32'(err_line), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_output", 32'(m_valid), 32'd0);

    // Recovery frame after reset.
    write_set(16, 32, 64);
    fill_rand();
    model_frame(4, 0);
    send_frame(4, -1);
    drain();

    // Full-width line without s_last also flags an error.
    check("err_before_nolast", 32'(err_line), 32'd0);
    for (int c = 0; c < IW; c++) send_pix(8'd9, (c == 0), 1'b0);
    check("err_missing_last", 32'(err_line), 32'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
